// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, FLUSH and bubble masking.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid stage; otherwise the stage holds a single entry.
module pipe_stage_reg #(
  parameter int                DATA_W    = 110,
  parameter logic [DATA_W-1:0] KILL_MASK = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_count
);

  // The state encoding equals the number of held entries.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] FULL  = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              push, pop;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  // in_ready comes from registered state only, so it never depends on out_ready.
  assign in_ready = ENABLE & (state_q != FULL);
`else
  assign in_ready = ENABLE & ((state_q == EMPTY) | out_ready);
`endif

  assign out_valid = ENABLE & (state_q != EMPTY);
  assign out_data  = (state_q == EMPTY) ? (main_q & ~KILL_MASK) : main_q;
  assign out_count = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (FLUSH) begin
      state_d = EMPTY;
      main_d  = main_q & ~KILL_MASK;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = skid_q & ~KILL_MASK;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
`endif
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with KILL_MASK=0xF; follows PIPE_STAGE_SKID_EN like the design.
module tb_pipe_stage_reg;

  localparam int            DW = 110;
  localparam logic [DW-1:0] KM = 110'hF;

  logic          CLK = 1'b0;
  logic          RESET, ENABLE, FLUSH, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_count;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(DW), .KILL_MASK(KM)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .FLUSH     (FLUSH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    int            cnt, got, sent;
    logic          exp_rdy, do_push, do_pop;

    RESET = 1'b1; ENABLE = 1'b0; FLUSH = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    RESET = 1'b0; ENABLE = 1'b1;
    #1;
    check_eq("rst_count", out_count, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_data", out_data, 0);

    // single push, visible one edge later
    in_valid = 1'b1; in_data = 'hAA; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check_eq("push_out_valid", out_valid, 1);
    check_eq("push_out_data", out_data, 'hAA);
    check_eq("push_count", out_count, 1);
    step();
    check_eq("pop_count", out_count, 0);
    check_eq("pop_out_valid", out_valid, 0);
    check_eq("bubble_masked", out_data, 'hA0);

    // ENABLE=0 freezes a held entry
    in_valid = 1'b1; in_data = 'h55;
    step();
    ENABLE = 1'b0; in_data = 'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("frz_in_ready", in_ready, 0);
      check_eq("frz_out_valid", out_valid, 0);
      check_eq("frz_count", out_count, 1);
      check_eq("frz_data", out_data, 'h55);
    end
    ENABLE = 1'b1; in_valid = 1'b0;
    step();
    check_eq("frz_drain", out_count, 0);

`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h1;
    step();
    in_data = 'h2;
    step();
    in_valid = 1'b0;
    #1;
    check_eq("skid_count2", out_count, 2);
    check_eq("skid_in_ready", in_ready, 0);
    check_eq("skid_head", out_data, 'h1);
    out_ready = 1'b1;
    step();
    check_eq("skid_count1", out_count, 1);
    check_eq("skid_second", out_data, 'h2);
    step();
    check_eq("skid_count0", out_count, 0);

    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h3F;
    step();
    in_data = 'h5F;
    step();
    check_eq("fl_full", out_count, 2);
`else
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h1;
    step();
    in_data = 'h2;
    #1;
    check_eq("d1_count", out_count, 1);
    check_eq("d1_in_ready_blk", in_ready, 0);
    step();
    check_eq("d1_hold", out_data, 'h1);
    out_ready = 1'b1;
    #1;
    check_eq("d1_in_ready_pass", in_ready, 1);
    step();
    check_eq("d1_replace", out_data, 'h2);
    check_eq("d1_count_rep", out_count, 1);
    in_valid = 1'b0;
    step();
    check_eq("d1_count0", out_count, 0);

    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h3F;
    step();
    in_data = 'h5F;
`endif
    // flush while holding data, with a push attempt in the same cycle
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("fl_count", out_count, 0);
    check_eq("fl_out_valid", out_valid, 0);
    check_eq("fl_low_nibble", out_data[3:0], 0);
    check_eq("fl_high_nibble", out_data[7:4], 'h3);

    // reset, flush and push together
    in_valid = 1'b1; in_data = 'h12;
    step();
    RESET = 1'b1; FLUSH = 1'b1; in_data = 'hFF; out_ready = 1'b1;
    step();
    RESET = 1'b0; FLUSH = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rf_count", out_count, 0);
    check_eq("rf_out_data", out_data, 0);
    check_eq("rf_out_valid", out_valid, 0);
    check_eq("rf_in_ready", in_ready, 1);

    // toggling out_ready with a continuous source, scoreboard for order
    cnt = 0; got = 0; sent = 0;
    for (int c = 0; c < 100 && got < 16; c++) begin
      out_ready = ((c % 2) == 0);
      in_valid  = 1'b1;
      in_data   = DW'('h100 + sent);
      #1;
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = (cnt != 2);
`else
      exp_rdy = (cnt == 0) || out_ready;
`endif
      check_eq("tog_in_ready", in_ready, exp_rdy);
      check_eq("tog_out_valid", out_valid, cnt != 0);
      do_pop  = (cnt != 0) && out_ready;
      do_push = exp_rdy;
      if (do_pop) begin
        check_eq("tog_order", out_data, q[0]);
        void'(q.pop_front());
        got++;
      end
      if (do_push) begin
        q.push_back(in_data);
        sent++;
      end
      cnt = cnt + int'(do_push) - int'(do_pop);
      step();
    end
    in_valid = 1'b0;
    check_eq("tog_transfers", got, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
